// File: rtl/mem_stage_pkg.sv
// Shared widths, register-file constants and load/store funct3 encodings
// for the memory-access stage and its neighbours.
package mem_stage_pkg;

    localparam int RegLen     = 32;
    localparam int RegAddrLen = 5;

    localparam logic [RegLen-1:0]     ZERO_WORD = '0;
    localparam logic [RegAddrLen-1:0] X0        = '0;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_e;

    // Index of the final byte of an access; anything not B or H moves a word.
    function automatic logic [1:0] last_byte_idx(input logic [2:0] funct3);
        if (funct3[1:0] == SB[1:0]) return 2'd0;
        if (funct3[1:0] == SH[1:0]) return 2'd1;
        if (funct3[1:0] == SW[1:0]) return 2'd3;
        return 2'd3;
    endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Sign/zero extension of an assembled load word according to funct3.
module load_extend
    import mem_stage_pkg::*;
(
    input  logic [RegLen-1:0] word,
    input  logic [2:0]        funct3,
    output logic [RegLen-1:0] ext
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        byte_s = word[7:0];
        half_s = word[15:0];
        case (funct3)
            LB:      ext = {{(RegLen-8){byte_s[7]}}, byte_s};
            LH:      ext = {{(RegLen-16){half_s[15]}}, half_s};
            LBU:     ext = {{(RegLen-8){1'b0}}, word[7:0]};
            LHU:     ext = {{(RegLen-16){1'b0}}, word[15:0]};
            LW:      ext = word;
            default: ext = word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: byte-serial loads/stores over an 8-bit port and a
// registered one-cycle write-back pulse toward the register file.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid_i,
    input  logic                  ex_load_i,
    input  logic                  ex_store_i,
    input  logic [2:0]            ex_funct3_i,
    input  logic                  ex_rd_en_i,
    input  logic [RegAddrLen-1:0] ex_rd_addr_i,
    input  logic [RegLen-1:0]     ex_result_i,
    input  logic [RegLen-1:0]     ex_store_data_i,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [RegLen-1:0]     mem_addr_o,
    output logic [7:0]            mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [7:0]            mem_rdata_i,
    output logic                  wb_enable_o,
    output logic [RegAddrLen-1:0] wb_addr_o,
    output logic [RegLen-1:0]     wb_data_o
);

    mem_state_e            state;
    logic [1:0]            k;
    logic [1:0]            k_last;
    logic                  store_p0;
    logic [RegLen-1:0]     addr_p0;
    logic [RegLen-1:0]     store_data_p0;
    logic [RegLen-1:0]     asm_p0;
    logic [2:0]            funct3_p0;
    logic [RegAddrLen-1:0] rd_p0;

    logic                  busy;
    logic                  accept_mem;
    logic [RegLen-1:0]     asm_next;
    logic [RegLen-1:0]     load_ext;

    assign busy       = (state == BUSY);
    assign accept_mem = (state == IDLE) && ex_valid_i && (ex_load_i || ex_store_i);
    assign stall_o    = busy || accept_mem;

    // Outputs are gated by BUSY so an async reset clears them immediately.
    assign mem_req_o   = busy;
    assign mem_we_o    = busy && store_p0;
    assign mem_addr_o  = busy ? addr_p0 + RegLen'(k) : ZERO_WORD;
    assign mem_wdata_o = busy ? store_data_p0[{k, 3'b000} +: 8] : 8'h00;

    always_comb begin
        asm_next = asm_p0;
        asm_next[{k, 3'b000} +: 8] = mem_rdata_i;
    end

    load_extend u_load_extend (
        .word   (asm_next),
        .funct3 (funct3_p0),
        .ext    (load_ext)
    );

    // p0: instruction latch and load assembly register
    always_ff @(posedge clk) begin
        if (accept_mem) begin
            addr_p0       <= ex_result_i;
            funct3_p0     <= ex_funct3_i;
            rd_p0         <= ex_rd_addr_i;
            store_data_p0 <= ex_store_data_i;
        end
        if (busy && mem_ack_i) begin
            asm_p0 <= asm_next;
        end
    end

    // p1: FSM, byte counter and registered write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            k           <= 2'd0;
            k_last      <= 2'd0;
            store_p0    <= 1'b0;
            wb_enable_o <= 1'b0;
            wb_addr_o   <= X0;
            wb_data_o   <= ZERO_WORD;
        end else begin
            wb_enable_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid_i) begin
                        if (ex_load_i || ex_store_i) begin
                            store_p0 <= ex_store_i;
                            k        <= 2'd0;
                            k_last   <= last_byte_idx(ex_funct3_i);
                            state    <= BUSY;
                        end else begin
                            wb_enable_o <= ex_rd_en_i && (ex_rd_addr_i != X0);
                            wb_addr_o   <= ex_rd_addr_i;
                            wb_data_o   <= ex_result_i;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        k <= k + 2'd1;
                        if (k == k_last) begin
                            k     <= 2'd0;
                            state <= IDLE;
                            if (!store_p0) begin
                                wb_enable_o <= (rd_p0 != X0);
                                wb_addr_o   <= rd_p0;
                                wb_data_o   <= load_ext;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized traffic against a
// byte-level memory model and a cycle-indexed write-back expectation table.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  ex_valid_i = 1'b0;
    logic                  ex_load_i = 1'b0;
    logic                  ex_store_i = 1'b0;
    logic [2:0]            ex_funct3_i = 3'b000;
    logic                  ex_rd_en_i = 1'b0;
    logic [RegAddrLen-1:0] ex_rd_addr_i = '0;
    logic [RegLen-1:0]     ex_result_i = '0;
    logic [RegLen-1:0]     ex_store_data_i = '0;
    logic                  stall_o;
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [RegLen-1:0]     mem_addr_o;
    logic [7:0]            mem_wdata_o;
    logic                  mem_ack_i = 1'b0;
    logic [7:0]            mem_rdata_i = 8'h00;
    logic                  wb_enable_o;
    logic [RegAddrLen-1:0] wb_addr_o;
    logic [RegLen-1:0]     wb_data_o;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_valid_i      (ex_valid_i),
        .ex_load_i       (ex_load_i),
        .ex_store_i      (ex_store_i),
        .ex_funct3_i     (ex_funct3_i),
        .ex_rd_en_i      (ex_rd_en_i),
        .ex_rd_addr_i    (ex_rd_addr_i),
        .ex_result_i     (ex_result_i),
        .ex_store_data_i (ex_store_data_i),
        .stall_o         (stall_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_ack_i       (mem_ack_i),
        .mem_rdata_i     (mem_rdata_i),
        .wb_enable_o     (wb_enable_o),
        .wb_addr_o       (wb_addr_o),
        .wb_data_o       (wb_data_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic        last;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
    } xfer_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    xfer_t       exp_q[$];
    wb_t         exp_wb[int];
    logic [7:0]  mem[logic [31:0]];
    logic [31:0] ack_addrs[$];
    int          ack_cycs[$];

    int          n_vec = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          wait_mode = 0;
    int          wb_count = 0;
    int          last_wb_cyc = -1;
    logic [31:0] last_wb_data = '0;
    logic [4:0]  last_wb_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    endtask

    // Untouched memory returns an address-derived pattern.
    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] w);
        int v;
        case (f3)
            3'b000: begin v = int'(w & 32'hFF);   if (v >= 128)   v -= 256;   end
            3'b001: begin v = int'(w & 32'hFFFF); if (v >= 32768) v -= 65536; end
            3'b100: v = int'(w & 32'hFF);
            3'b101: v = int'(w & 32'hFFFF);
            default: v = int'(w);
        endcase
        return 32'(v);
    endfunction

    // Compare process: write-back every cycle, memory requests, and the responder.
    initial begin : compare
        int    wleft;
        bit    counting;
        xfer_t h;
        wleft = 0;
        counting = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                exp_wb.delete();
                counting = 0;
                mem_ack_i = 1'b0;
                continue;
            end
            if (exp_wb.exists(cyc)) begin
                check("wb_enable", wb_enable_o, 1'b1);
                check("wb_addr", wb_addr_o, exp_wb[cyc].addr);
                check("wb_data", wb_data_o, exp_wb[cyc].data);
                exp_wb.delete(cyc);
            end else begin
                check("wb_enable_idle", wb_enable_o, 1'b0);
            end
            if (wb_enable_o) begin
                wb_count++;
                last_wb_cyc  = cyc;
                last_wb_data = wb_data_o;
                last_wb_addr = wb_addr_o;
            end
            mem_ack_i = 1'b0;
            if (mem_req_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_req", mem_req_o, 1'b0);
                end else begin
                    h = exp_q[0];
                    check("mem_addr", mem_addr_o, h.addr);
                    check("mem_we", mem_we_o, h.we);
                    if (h.we) check("mem_wdata", mem_wdata_o, h.wdata);
                    if (!counting) begin
                        counting = 1;
                        wleft = (wait_mode < 0) ? int'($urandom_range(3, 0)) : wait_mode;
                    end
                    if (wleft == 0) begin
                        mem_ack_i   = 1'b1;
                        mem_rdata_i = rd_byte(mem_addr_o);
                        if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
                        ack_addrs.push_back(mem_addr_o);
                        ack_cycs.push_back(cyc);
                        if (h.last && h.wb_en) exp_wb[cyc + 1] = '{h.wb_addr, h.wb_data};
                        void'(exp_q.pop_front());
                        counting = 0;
                    end else begin
                        wleft--;
                    end
                end
            end
        end
    end

    task automatic present(input bit ld, input bit st, input logic [2:0] f3, input bit rd_en,
                           input logic [4:0] rd, input logic [31:0] res, input logic [31:0] sd,
                           output int icyc, output logic [31:0] exp_data);
        int          n;
        logic [31:0] word;
        xfer_t       x;
        ex_valid_i = 1'b1;
        ex_load_i = ld;
        ex_store_i = st;
        ex_funct3_i = f3;
        ex_rd_en_i = rd_en;
        ex_rd_addr_i = rd;
        ex_result_i = res;
        ex_store_data_i = sd;
        icyc = cyc;
        exp_data = '0;
        #1;
        check("stall_on_present", stall_o, ld || st);
        if (!ld && !st) begin
            exp_data = res;
            if (rd_en && rd != 5'd0) exp_wb[cyc + 1] = '{rd, res};
        end else begin
            n = nbytes(f3);
            word = '0;
            for (int i = 0; i < n; i++) word |= 32'(rd_byte(res + 32'(i))) << (8 * i);
            if (ld) exp_data = model_load(f3, word);
            for (int i = 0; i < n; i++) begin
                x.addr    = res + 32'(i);
                x.we      = st;
                x.wdata   = 8'(sd >> (8 * i));
                x.last    = (i == n - 1);
                x.wb_en   = ld && (rd != 5'd0);
                x.wb_addr = rd;
                x.wb_data = exp_data;
                exp_q.push_back(x);
            end
        end
    endtask

    task automatic complete(output int busy_cycles);
        int guard;
        guard = 0;
        busy_cycles = 0;
        @(negedge clk);
        #1;
        ex_valid_i = 1'b0;
        #1;
        while (stall_o && guard < 300) begin
            busy_cycles++;
            guard++;
            @(negedge clk);
            #1;
        end
        if (stall_o) begin
            check("stall_timeout", stall_o, 1'b0);
            summary();
        end
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        summary();
    end

    initial begin : main
        int          ic;
        int          bc;
        int          wbc;
        int          guard;
        int          kind;
        logic [31:0] ed;
        logic [31:0] res;
        logic [2:0]  f3;
        logic [2:0]  lf3[8];
        lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

        repeat (3) @(negedge clk);
        #1;
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_mem_we", mem_we_o, 1'b0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_mem_wdata", mem_wdata_o, 8'h00);
        check("rst_wb_enable", wb_enable_o, 1'b0);
        check("rst_wb_addr", wb_addr_o, 5'd0);
        check("rst_wb_data", wb_data_o, 32'h0);
        check("rst_stall", stall_o, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // ADD pass-through
        present(0, 0, 3'b000, 1, 5'd5, 32'h0000_1234, 32'h0, ic, ed);
        complete(bc);
        check("add_wb_data", last_wb_data, 32'h0000_1234);
        check("add_wb_addr", last_wb_addr, 5'd5);
        check("add_wb_cycle", last_wb_cyc, ic + 1);
        check("add_stall_cycles", bc, 0);

        // LB, zero-wait
        wait_mode = 0;
        mem[32'h100] = 8'h80;
        ack_addrs.delete();
        ack_cycs.delete();
        present(1, 0, LB, 1, 5'd7, 32'h100, 32'h0, ic, ed);
        check("lb_model", ed, 32'hFFFF_FF80);
        complete(bc);
        check("lb_ack_count", ack_addrs.size(), 1);
        if (ack_addrs.size() > 0) begin
            check("lb_addr", ack_addrs[0], 32'h100);
            check("lb_req_cycle", ack_cycs[0], ic + 1);
        end
        check("lb_wb_cycle", last_wb_cyc, ic + 2);
        check("lb_wb_data", last_wb_data, 32'hFFFF_FF80);

        // Misaligned LW with two wait cycles per byte
        wait_mode = 2;
        mem[32'h203] = 8'h11;
        mem[32'h204] = 8'h22;
        mem[32'h205] = 8'h33;
        mem[32'h206] = 8'h44;
        ack_addrs.delete();
        present(1, 0, LW, 1, 5'd9, 32'h203, 32'h0, ic, ed);
        check("lw_model", ed, 32'h4433_2211);
        complete(bc);
        check("lw_stall_cycles", bc, 12);
        check("lw_ack_count", ack_addrs.size(), 4);
        for (int i = 0; i < 4 && i < ack_addrs.size(); i++)
            check("lw_addr_order", ack_addrs[i], 32'h203 + 32'(i));
        check("lw_wb_data", last_wb_data, 32'h4433_2211);
        check("lw_wb_cycle", last_wb_cyc, ic + 13);

        // SH across the address wrap
        wait_mode = 1;
        ack_addrs.delete();
        wbc = wb_count;
        present(0, 1, SH, 1, 5'd4, 32'hFFFF_FFFF, 32'hDEAD_BEEF, ic, ed);
        complete(bc);
        check("sh_byte0", rd_byte(32'hFFFF_FFFF), 8'hEF);
        check("sh_byte1", rd_byte(32'h0), 8'hBE);
        check("sh_ack_count", ack_addrs.size(), 2);
        if (ack_addrs.size() == 2) check("sh_wrap_addr", ack_addrs[1], 32'h0);
        check("sh_no_wb", wb_count, wbc);

        // LHU to x0, then to x3
        wait_mode = 0;
        mem[32'h400] = 8'h00;
        mem[32'h401] = 8'h90;
        wbc = wb_count;
        present(1, 0, LHU, 1, 5'd0, 32'h400, 32'h0, ic, ed);
        complete(bc);
        check("lhu_x0_no_wb", wb_count, wbc);
        present(1, 0, LHU, 1, 5'd3, 32'h400, 32'h0, ic, ed);
        check("lhu_model", ed, 32'h0000_9000);
        complete(bc);
        check("lhu_wb_data", last_wb_data, 32'h0000_9000);
        check("lhu_wb_addr", last_wb_addr, 5'd3);

        // Reset during the third byte of an LW
        wait_mode = 2;
        ack_addrs.delete();
        wbc = wb_count;
        present(1, 0, LW, 1, 5'd6, 32'h500, 32'h0, ic, ed);
        @(negedge clk);
        #1;
        ex_valid_i = 1'b0;
        guard = 0;
        while (ack_addrs.size() < 2 && guard < 50) begin
            guard++;
            @(negedge clk);
            #1;
        end
        check("rst_mid_progress", ack_addrs.size(), 2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_req_drop", mem_req_o, 1'b0);
        check("rst_mid_stall", stall_o, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mid_no_wb", wb_count, wbc);
        wait_mode = 0;
        mem[32'h600] = 8'h7F;
        present(1, 0, LB, 1, 5'd8, 32'h600, 32'h0, ic, ed);
        complete(bc);
        check("post_rst_lb_data", last_wb_data, 32'h0000_007F);
        check("post_rst_lb_count", wb_count, wbc + 1);

        // Randomized traffic
        wait_mode = -1;
        for (int n = 0; n < 250; n++) begin
            kind = int'($urandom_range(2, 0));
            res = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(3, 0)) : $urandom;
            if (kind == 1) f3 = lf3[$urandom_range(7, 0)];
            else           f3 = 3'($urandom_range(2, 0));
            present(kind == 1, kind == 2, f3, 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)),
                    res, $urandom, ic, ed);
            complete(bc);
            if ($urandom_range(3, 0) == 0) begin
                repeat ($urandom_range(2, 1)) @(negedge clk);
                #1;
            end
        end
        repeat (3) @(negedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 0);
        summary();
    end

endmodule
